// File: rtl/vectored_int_ctrl.sv
// vectored_int_ctrl: captures accelerator done edges, arbitrates by fixed priority
// and runs the CPU req/ack/vector/eoi handshake with registered outputs.
module vectored_int_ctrl #(
  parameter int          NSRC   = 4,
  parameter logic [29:0] VEC_HI = 30'h3FFFFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] done_i,
  input  logic            mask_we_i,
  input  logic [NSRC-1:0] mask_wd_i,
  input  logic            int_ack_i,
  input  logic            eoi_i,
  input  logic            ovf_clr_i,
  output logic            int_req_o,
  output logic            int_valid_o,
  output logic [31:0]     int_addr_o,
  output logic [1:0]      int_id_o,
  output logic [NSRC-1:0] pending_o,
  output logic [NSRC-1:0] ovf_o
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, VEC = 2'd2, SERVICE = 2'd3;
  logic [NSRC-1:0] done_q, pending_q, pending_d, mask_q, mask_d, ovf_q, ovf_d;
  logic [NSRC-1:0] rise, eligible, clr;
  logic [1:0]      state_q, state_d, id_q, id_d, win;
  logic            req_q, req_d, valid_q, valid_d, armed_q;
  always_comb begin
    // done levels held through reset must not look like edges once it releases
    rise     = done_i & ~done_q & {NSRC{armed_q}};
    eligible = pending_q & mask_q;
    win      = '0;
    for (int i = 0; i < NSRC; i++) if (eligible[i]) win = 2'(i);
    state_d = state_q;
    req_d   = req_q;
    valid_d = valid_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IDLE: if (eligible != '0) begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: if (eligible == '0) begin
        state_d = IDLE;
        req_d   = 1'b0;
      end else if (int_ack_i) begin
        state_d = VEC;
        req_d   = 1'b0;
        valid_d = 1'b1;
        id_d    = win;
        clr     = NSRC'(1) << win;
      end
      VEC: if (!int_ack_i) begin
        state_d = SERVICE;
        valid_d = 1'b0;
      end
      default: state_d = eoi_i ? IDLE : state_q;
    endcase
    pending_d = (pending_q & ~clr) | rise;
    ovf_d     = (ovf_clr_i ? '0 : ovf_q) | (rise & pending_q);
    mask_d    = mask_we_i ? mask_wd_i : mask_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= '0;
      armed_q   <= 1'b0;
      pending_q <= '0;
      mask_q    <= '1;
      ovf_q     <= '0;
      id_q      <= '0;
      state_q   <= IDLE;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      done_q    <= done_i;
      armed_q   <= 1'b1;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
      id_q      <= id_d;
      state_q   <= state_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end
  assign int_req_o   = req_q;
  assign int_valid_o = valid_q;
  assign int_addr_o  = {VEC_HI, id_q};
  assign int_id_o    = id_q;
  assign pending_o   = pending_q;
  assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_vectored_int_ctrl.sv
// tb_vectored_int_ctrl: vector table, directed corner sequences and randomized
// traffic checked against a rule-level model of the interrupt scheduler.
module tb_vectored_int_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  done = 4'hF, mask_wd = 4'h0;
  logic        mask_we = 1'b0, ack = 1'b0, eoi = 1'b0, ovf_clr = 1'b0;
  logic        req, valid;
  logic [31:0] addr;
  logic [1:0]  id;
  logic [3:0]  pend, ovf;
  int n_chk = 0, n_fail = 0;

  vectored_int_ctrl dut (
    .clk(clk), .rst(rst), .done_i(done), .mask_we_i(mask_we), .mask_wd_i(mask_wd),
    .int_ack_i(ack), .eoi_i(eoi), .ovf_clr_i(ovf_clr), .int_req_o(req),
    .int_valid_o(valid), .int_addr_o(addr), .int_id_o(id), .pending_o(pend), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: pending/mask/overflow as per-source flags, handshake as a phase number
  bit [3:0] m_prev, m_pend, m_mask, m_ovf, m_rise;
  bit       m_armed, m_req, m_valid;
  bit [1:0] m_id;
  int       m_phase, m_win, m_clr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = 0; m_armed = 0; m_pend = 0; m_mask = 4'hF; m_ovf = 0;
      m_id = 0; m_phase = 0; m_req = 0; m_valid = 0;
    end else begin
      m_rise = m_armed ? (done & ~m_prev) : 4'h0;
      m_win = -1;
      for (int i = 0; i < 4; i++) if (m_pend[i] && m_mask[i]) m_win = i;
      m_clr = -1;
      if (m_phase == 0) begin
        if (m_win >= 0) begin m_phase = 1; m_req = 1; end
      end else if (m_phase == 1) begin
        if (m_win < 0) begin m_phase = 0; m_req = 0; end
        else if (ack) begin m_id = 2'(m_win); m_clr = m_win; m_valid = 1; m_req = 0; m_phase = 2; end
      end else if (m_phase == 2) begin
        if (!ack) begin m_valid = 0; m_phase = 3; end
      end else if (eoi) m_phase = 0;
      for (int i = 0; i < 4; i++) begin
        if (ovf_clr) m_ovf[i] = 0;
        if (m_rise[i] && m_pend[i]) m_ovf[i] = 1;
        if (m_rise[i]) m_pend[i] = 1;
        else if (i == m_clr) m_pend[i] = 0;
      end
      if (mask_we) m_mask = mask_wd;
      m_prev = done;
      m_armed = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  done;
    logic        ack, eoi, exp_req, exp_valid;
    logic [31:0] exp_addr;
    logic [3:0]  exp_pend;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{4'b0010, 0, 0, 0, 0, 32'hFFFFFFFC, 4'b0010};
    tbl[1]  = '{4'b0010, 0, 0, 1, 0, 32'hFFFFFFFC, 4'b0010};
    tbl[2]  = '{4'b0010, 1, 0, 0, 1, 32'hFFFFFFFD, 4'b0000};
    tbl[3]  = '{4'b0010, 0, 0, 0, 0, 32'hFFFFFFFD, 4'b0000};
    tbl[4]  = '{4'b0010, 0, 1, 0, 0, 32'hFFFFFFFD, 4'b0000};
    tbl[5]  = '{4'b0000, 0, 0, 0, 0, 32'hFFFFFFFD, 4'b0000};
    tbl[6]  = '{4'b0101, 0, 0, 0, 0, 32'hFFFFFFFD, 4'b0101};
    tbl[7]  = '{4'b0101, 0, 0, 1, 0, 32'hFFFFFFFD, 4'b0101};
    tbl[8]  = '{4'b0101, 1, 0, 0, 1, 32'hFFFFFFFE, 4'b0001};
    tbl[9]  = '{4'b0101, 0, 0, 0, 0, 32'hFFFFFFFE, 4'b0001};
    tbl[10] = '{4'b0101, 0, 1, 0, 0, 32'hFFFFFFFE, 4'b0001};
    tbl[11] = '{4'b0101, 0, 0, 1, 0, 32'hFFFFFFFE, 4'b0001};
    tbl[12] = '{4'b0101, 1, 0, 0, 1, 32'hFFFFFFFC, 4'b0000};
    tbl[13] = '{4'b0101, 0, 0, 0, 0, 32'hFFFFFFFC, 4'b0000};
    tbl[14] = '{4'b0000, 0, 1, 0, 0, 32'hFFFFFFFC, 4'b0000};

    // Reset held with done high, then released: no edge may be seen
    tick(); tick();
    chk("reset_outputs", {req, valid, id, pend, ovf, addr}, {2'b00, 2'd0, 4'h0, 4'h0, 32'hFFFFFFFC});
    rst = 1'b0;
    tick(); tick(); tick();
    chk("release_no_edge", {req, pend}, {1'b0, 4'h0});
    done = 4'h0;
    tick();

    // Single source and priority sequences from the table
    foreach (tbl[r]) begin
      done = tbl[r].done; ack = tbl[r].ack; eoi = tbl[r].eoi;
      tick();
      chk($sformatf("tbl%0d_req", r), req, tbl[r].exp_req);
      chk($sformatf("tbl%0d_valid", r), valid, tbl[r].exp_valid);
      chk($sformatf("tbl%0d_addr_pend", r), {addr, pend}, {tbl[r].exp_addr, tbl[r].exp_pend});
    end
    eoi = 0;

    // Masked source latches without request; late higher-priority arrival wins at ack
    mask_we = 1; mask_wd = 4'b1011; tick();
    mask_we = 0; done = 4'b0100; tick(); tick();
    chk("masked_no_req", {req, pend}, {1'b0, 4'b0100});
    mask_we = 1; mask_wd = 4'hF; tick();
    mask_we = 0; tick();
    chk("unmask_req", req, 1'b1);
    done = 4'b1100; tick();
    chk("late_arrival_pend", {req, pend}, {1'b1, 4'b1100});
    ack = 1; tick();
    chk("late_arrival_vec", {valid, addr, pend}, {1'b1, 32'hFFFFFFFF, 4'b0100});
    ack = 0; tick(); eoi = 1; tick(); eoi = 0; tick();
    chk("b2b_req", req, 1'b1);
    ack = 1; tick();
    chk("b2b_vec", {valid, addr}, {1'b1, 32'hFFFFFFFE});
    ack = 0; tick(); eoi = 1; tick(); eoi = 0; done = 4'h0; tick();

    // Overflow: second edge while pending, one service, then clear
    done = 4'b0010; tick();
    done = 4'b0000; tick();
    done = 4'b0010; tick();
    chk("ovf_set", {req, ovf}, {1'b1, 4'b0010});
    ack = 1; tick();
    chk("ovf_vec", {valid, addr, pend}, {1'b1, 32'hFFFFFFFD, 4'b0000});
    ack = 0; tick(); eoi = 1; tick(); eoi = 0; tick();
    chk("ovf_single_service", {req, ovf}, {1'b0, 4'b0010});
    ovf_clr = 1; tick();
    chk("ovf_clr", ovf, 4'b0000);
    ovf_clr = 0; done = 4'h0; tick();

    // Mask drop while requesting, then async reset during the vector phase
    done = 4'b1000; tick(); tick();
    chk("pre_drop_req", req, 1'b1);
    mask_we = 1; mask_wd = 4'h0; tick();
    mask_we = 0; tick();
    chk("mask_drop", {req, pend}, {1'b0, 4'b1000});
    mask_we = 1; mask_wd = 4'hF; tick();
    mask_we = 0; tick();
    chk("remask_req", req, 1'b1);
    ack = 1; tick();
    chk("pre_rst_vec", {valid, addr}, {1'b1, 32'hFFFFFFFF});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {req, valid, id, pend, ovf, addr}, {2'b00, 2'd0, 4'h0, 4'h0, 32'hFFFFFFFC});
    rst = 1'b0; ack = 0;
    tick(); tick(); tick();
    chk("post_rst_quiet", {req, valid, pend}, {2'b00, 4'h0});

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) done[b] = ~done[b];
      ack     = ($urandom_range(2) == 0);
      eoi     = ($urandom_range(3) == 0);
      mask_we = ($urandom_range(15) == 0);
      mask_wd = 4'($urandom);
      ovf_clr = ($urandom_range(15) == 0);
      tick();
      chk($sformatf("rand%0d", c), {req, valid, id, pend, ovf, addr},
          {m_req, m_valid, m_id, m_pend, m_ovf, 30'h3FFFFFFF, m_id});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
